// File: rtl/triangle_pixel_scanner.sv
// Triangle front end: latches three Q16.16 vertices, builds the screen-clamped integer
// bounding box and emits every pixel inside it, one per cycle, in raster order.
module triangle_pixel_scanner #(
  parameter int SCREEN_W  = 320,
  parameter int SCREEN_H  = 240,
  parameter int FRAC_BITS = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic signed [31:0] i_v1_x,
  input  logic signed [31:0] i_v1_y,
  input  logic signed [31:0] i_v2_x,
  input  logic signed [31:0] i_v2_y,
  input  logic signed [31:0] i_v3_x,
  input  logic signed [31:0] i_v3_y,
  input  logic               i_stall,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_write_enable,
  output logic signed [15:0] o_x_pos,
  output logic signed [15:0] o_y_pos,
  output logic signed [31:0] o_vp_x,
  output logic signed [31:0] o_vp_y,
  output logic signed [31:0] o_v1_x,
  output logic signed [31:0] o_v1_y,
  output logic signed [31:0] o_v2_x,
  output logic signed [31:0] o_v2_y,
  output logic signed [31:0] o_v3_x,
  output logic signed [31:0] o_v3_y
);

  // Pixel-output handshake: o_write_enable=1 marks o_x_pos/o_y_pos/o_vp_* valid for one
  // cycle; i_stall=1 (downstream not ready) holds the pending pixel and drops the enable.
  typedef enum logic [1:0] {ST_IDLE, ST_BBOX, ST_SCAN, ST_DONE} state_e;

  localparam logic signed [31:0] X_LAST = 32'(SCREEN_W - 1);
  localparam logic signed [31:0] Y_LAST = 32'(SCREEN_H - 1);
  localparam logic signed [31:0] HALF   = 32'sd1 <<< (FRAC_BITS - 1);

  state_e             state_q;
  logic               busy_q, done_q, we_q;
  logic signed [31:0] v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q;
  logic signed [15:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic signed [15:0] x_q, y_q, xpos_q, ypos_q;
  logic signed [31:0] vpx_q, vpy_q;

  logic signed [31:0] min_x_d, max_x_d, min_y_d, max_y_d;
  logic signed [31:0] lo_x_d, hi_x_d, lo_y_d, hi_y_d;
  logic signed [31:0] vpx_d, vpy_d;
  logic               empty_d, last_d;

  function automatic logic signed [31:0] min3(input logic signed [31:0] a, b, c);
    logic signed [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [31:0] max3(input logic signed [31:0] a, b, c);
    logic signed [31:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  always_comb begin
    // Arithmetic shift of the signed extreme is floor() for negative coordinates too.
    min_x_d = min3(v1x_q, v2x_q, v3x_q) >>> FRAC_BITS;
    max_x_d = max3(v1x_q, v2x_q, v3x_q) >>> FRAC_BITS;
    min_y_d = min3(v1y_q, v2y_q, v3y_q) >>> FRAC_BITS;
    max_y_d = max3(v1y_q, v2y_q, v3y_q) >>> FRAC_BITS;
    lo_x_d  = (min_x_d < 32'sd0) ? 32'sd0 : min_x_d;
    hi_x_d  = (max_x_d > X_LAST) ? X_LAST : max_x_d;
    lo_y_d  = (min_y_d < 32'sd0) ? 32'sd0 : min_y_d;
    hi_y_d  = (max_y_d > Y_LAST) ? Y_LAST : max_y_d;
    empty_d = (lo_x_d > hi_x_d) || (lo_y_d > hi_y_d);
    last_d  = (x_q == xmax_q) && (y_q == ymax_q);
    vpx_d   = (32'(x_q) <<< FRAC_BITS) + HALF;
    vpy_d   = (32'(y_q) <<< FRAC_BITS) + HALF;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      v1x_q   <= '0;
      v1y_q   <= '0;
      v2x_q   <= '0;
      v2y_q   <= '0;
      v3x_q   <= '0;
      v3y_q   <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      vpx_q   <= '0;
      vpy_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          we_q   <= 1'b0;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (i_start) begin
            v1x_q   <= i_v1_x;
            v1y_q   <= i_v1_y;
            v2x_q   <= i_v2_x;
            v2y_q   <= i_v2_y;
            v3x_q   <= i_v3_x;
            v3y_q   <= i_v3_y;
            busy_q  <= 1'b1;
            state_q <= ST_BBOX;
          end
        end
        ST_BBOX: begin
          // Truncation to 16 bits is safe whenever the box is non-empty.
          xmin_q  <= lo_x_d[15:0];
          xmax_q  <= hi_x_d[15:0];
          ymin_q  <= lo_y_d[15:0];
          ymax_q  <= hi_y_d[15:0];
          x_q     <= lo_x_d[15:0];
          y_q     <= lo_y_d[15:0];
          state_q <= empty_d ? ST_DONE : ST_SCAN;
        end
        ST_SCAN: begin
          if (i_stall) begin
            we_q <= 1'b0;
          end else begin
            we_q   <= 1'b1;
            xpos_q <= x_q;
            ypos_q <= y_q;
            vpx_q  <= vpx_d;
            vpy_q  <= vpy_d;
            if (last_d) begin
              state_q <= ST_DONE;
            end else if (x_q < xmax_q) begin
              x_q <= x_q + 16'sd1;
            end else begin
              x_q <= xmin_q;
              y_q <= y_q + 16'sd1;
            end
          end
        end
        ST_DONE: begin
          we_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_write_enable = we_q;
  assign o_x_pos        = xpos_q;
  assign o_y_pos        = ypos_q;
  assign o_vp_x         = vpx_q;
  assign o_vp_y         = vpy_q;
  assign o_v1_x         = v1x_q;
  assign o_v1_y         = v1y_q;
  assign o_v2_x         = v2x_q;
  assign o_v2_y         = v2y_q;
  assign o_v3_x         = v3x_q;
  assign o_v3_y         = v3y_q;

endmodule

// File: tb/tb_triangle_pixel_scanner.sv
// Directed bench for triangle_pixel_scanner: hand-computed bounding boxes feed an expected
// pixel queue that every emitted pixel is checked against, plus timing and reset checks.
module tb_triangle_pixel_scanner;

  logic        clk, rst_n, start, stall;
  logic [31:0] v1x, v1y, v2x, v2y, v3x, v3y;
  logic        o_busy, o_done, o_we;
  logic [15:0] o_x_pos, o_y_pos;
  logic [31:0] o_vp_x, o_vp_y;
  logic [31:0] o_v1_x, o_v1_y, o_v2_x, o_v2_y, o_v3_x, o_v3_y;

  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  triangle_pixel_scanner #(.SCREEN_W(320), .SCREEN_H(240), .FRAC_BITS(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_v1_x(v1x), .i_v1_y(v1y), .i_v2_x(v2x), .i_v2_y(v2y), .i_v3_x(v3x), .i_v3_y(v3y),
    .i_stall(stall),
    .o_busy(o_busy), .o_done(o_done), .o_write_enable(o_we),
    .o_x_pos(o_x_pos), .o_y_pos(o_y_pos), .o_vp_x(o_vp_x), .o_vp_y(o_vp_y),
    .o_v1_x(o_v1_x), .o_v1_y(o_v1_y), .o_v2_x(o_v2_x), .o_v2_y(o_v2_y),
    .o_v3_x(o_v3_x), .o_v3_y(o_v3_y)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{o_busy, o_done, o_we, o_x_pos, o_y_pos, o_vp_x, o_vp_y,
             o_v1_x, o_v1_y, o_v2_x, o_v2_y, o_v3_x, o_v3_y};
  endfunction

  task automatic set_tri(input logic [31:0] ax, ay, bx, by, cx, cy);
    v1x = ax; v1y = ay; v2x = bx; v2y = by; v3x = cx; v3y = cy;
  endtask

  // Runs the latched triangle; stall_idx >= 0 stalls 3 cycles once that many pixels are out
  // and pulses a bogus start at the same time.
  task automatic run_tri(input string name, input int exmin, exmax, eymin, eymax,
                         input int stall_idx);
    int          cyc, n_we, first_we, last_we, done_cyc, stall_cnt, n_exp;
    bit          busy_ok, stall_used, stall_done, empty;
    logic [31:0] exp_px, last_px, saved_v1x;
    empty = (exmin > exmax) || (eymin > eymax);
    n_exp = 0;
    if (!empty)
      for (int y = eymin; y <= eymax; y++)
        for (int x = exmin; x <= exmax; x++) begin
          exp_q.push_back({16'(x), 16'(y)});
          n_exp++;
        end
    saved_v1x = v1x;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "/v1x"}, o_v1_x, v1x);
    check({name, "/v3y"}, o_v3_y, v3y);
    cyc = 0; n_we = 0; first_we = -1; last_we = -1; done_cyc = -1; stall_cnt = 0;
    busy_ok = 1'b1; stall_used = 1'b0; stall_done = 1'b0; last_px = '0;
    while (cyc < 3000) begin
      if (!o_busy) busy_ok = 1'b0;
      if (stall_used) check({name, "/stall_we"}, o_we, 1'b0);
      if (o_we) begin
        if (exp_q.size() == 0) begin
          check({name, "/extra_px"}, {o_x_pos, o_y_pos}, 32'hxxxx_xxxx);
        end else begin
          exp_px = exp_q.pop_front();
          check({name, "/px"}, {o_x_pos, o_y_pos}, exp_px);
          check({name, "/vpx"}, o_vp_x, {exp_px[31:16], 16'h8000});
          check({name, "/vpy"}, o_vp_y, {exp_px[15:0], 16'h8000});
          if (name == "t1" && exp_px == 32'h0001_0000)
            check("t1/vp_1_0", o_vp_x, 32'h0001_8000);
        end
        last_px = {o_x_pos, o_y_pos};
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
        n_we++;
      end
      if (o_done) begin
        done_cyc = cyc;
        break;
      end
      if (stall_cnt > 0) begin
        stall_cnt--;
        start = 1'b0;
        v1x = saved_v1x;
        if (stall_cnt == 0) stall = 1'b0;
      end else if (stall_idx >= 0 && !stall_done && n_we == stall_idx) begin
        stall = 1'b1;
        start = 1'b1;
        v1x = 32'h7FFF_0000;
        stall_cnt = 3;
        stall_done = 1'b1;
      end
      stall_used = stall;
      @(negedge clk);
      cyc++;
    end
    if (done_cyc < 0) check({name, "/timeout"}, 1'b0, 1'b1);
    check({name, "/count"}, n_we, n_exp);
    check({name, "/leftover"}, exp_q.size(), 0);
    check({name, "/busy_held"}, busy_ok, 1'b1);
    if (empty) begin
      check({name, "/done_lat"}, done_cyc, 2);
    end else begin
      check({name, "/first_lat"}, first_we, 2);
      check({name, "/done_after_last"}, done_cyc, last_we + 1);
      check({name, "/last_px"}, last_px, {16'(exmax), 16'(eymax)});
      check({name, "/span"}, last_we - first_we + 1, (stall_idx >= 0) ? n_exp + 3 : n_exp);
    end
    exp_q.delete();
    @(negedge clk);
    check({name, "/done_pulse"}, o_done, 1'b0);
    check({name, "/busy_drop"}, o_busy, 1'b0);
    check({name, "/we_idle"}, o_we, 1'b0);
    check({name, "/v1x_hold"}, o_v1_x, saved_v1x);
  endtask

  initial begin
    bit done_seen;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    set_tri('0, '0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("reset_outs", any_out(), 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // (0,0),(3,0),(0,2): 4x3 box
    set_tri(32'h0000_0000, 32'h0000_0000, 32'h0003_0000, 32'h0000_0000,
            32'h0000_0000, 32'h0002_0000);
    run_tri("t1", 0, 3, 0, 2, -1);
    run_tri("t1s", 0, 3, 0, 2, 6);

    // (1.5,0.25),(2.75,1.9),(1.1,3.0): x 1..2, y 0..3
    set_tri(32'h0001_8000, 32'h0000_4000, 32'h0002_C000, 32'h0001_E666,
            32'h0001_1999, 32'h0003_0000);
    run_tri("t2", 1, 2, 0, 3, -1);

    // (-5,-5),(2,-1),(1,400): clamped to x 0..2, y 0..239
    set_tri(32'hFFFB_0000, 32'hFFFB_0000, 32'h0002_0000, 32'hFFFF_0000,
            32'h0001_0000, 32'h0190_0000);
    run_tri("t3", 0, 2, 0, 239, -1);

    // (400,10),(500,10),(450,50): entirely right of the screen
    set_tri(32'h0190_0000, 32'h000A_0000, 32'h01F4_0000, 32'h000A_0000,
            32'h01C2_0000, 32'h0032_0000);
    run_tri("t4", 1, 0, 1, 0, -1);

    // Reset in the middle of a scan
    set_tri(32'h0000_0000, 32'h0000_0000, 32'h0003_0000, 32'h0000_0000,
            32'h0000_0000, 32'h0002_0000);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("rst/mid_we", o_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst/outs_zero", any_out(), 1'b0);
    done_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      done_seen |= o_done | o_busy | o_we;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      done_seen |= o_done | o_busy | o_we;
    end
    check("rst/no_done", done_seen, 1'b0);
    run_tri("t1r", 0, 3, 0, 2, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
